// File: rtl/if_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states and prefetch FIFO entry.
package if_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A PC may be fetched only if word-aligned and not beyond the last word of IM.
    function automatic logic pc_fetchable(input logic [31:0] pc, input logic [31:0] last_pc);
        return (pc <= last_pc) && (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with push, pop and single-cycle flush.
module if_prefetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;

    assign empty   = (count_q == '0);
    assign count_o = count_q;
    // Head is zero while empty so stale data never leaks to decode.
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads IM and queues {pc, instr} for decode.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IM_BYTES   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] Instr_addr,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_flushed
`endif
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] LAST_PC = 32'(IM_BYTES - INSTR_BYTES);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Redirect wins over the handshake: the head is flushed, not consumed.
    assign pop        = !fifo_empty && if_ready && !redirect_valid;
    assign push_entry = '{pc: pc_q, instr: Instruction};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
        end else if (state_q == FETCH) begin
            if (!pc_fetchable(pc_q, LAST_PC)) begin
                state_d = HALT;
            end else if (!fifo_full || pop) begin
                push = 1'b1;
                pc_d = pc_q + INSTR_BYTES;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign Instr_addr = pc_q;
    assign if_valid   = !fifo_empty;
    assign if_instr   = head.instr;
    assign if_pc      = head.pc;
    assign if_halted  = (state_q == HALT);

`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_flushed_q, perf_flushed_d;
    logic [16:0] flush_sum;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        flush_sum      = {1'b0, perf_flushed_q} + 17'(fifo_count);
        if (push && perf_fetched_q != 16'hFFFF) begin
            perf_fetched_d = perf_fetched_q + 16'd1;
        end
        if (redirect_valid) begin
            perf_flushed_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IMB   = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr_addr;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_halted;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] im [IMB/4];
    logic [31:0] q_pc [$];
    logic [31:0] q_ins [$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          m_fetched;
    int          m_flushed;

    always #5 clk = ~clk;

    assign Instruction = (Instr_addr < IMB) ? im[Instr_addr[6:2]] : (32'hBAD0_0000 ^ Instr_addr);

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH),
        .IM_BYTES   (IMB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Instr_addr     (Instr_addr),
        .Instruction    (Instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_halted      (if_halted)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_pc      = 32'h0;
        m_halt    = 1'b0;
        m_fetched = 0;
        m_flushed = 0;
    endtask

    // One clock edge of the reference behaviour, applied with the inputs of that cycle.
    task automatic model_edge(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit pop;
        if (rv) begin
            m_flushed = (m_flushed + q_pc.size() > 65535) ? 65535 : m_flushed + q_pc.size();
            q_pc.delete();
            q_ins.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            pop = (q_pc.size() > 0) && rdy;
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (!m_halt) begin
                if (m_pc > IMB - 4 || m_pc[1:0] != 2'b00) begin
                    m_halt = 1'b1;
                end else if (q_pc.size() < DEPTH) begin
                    q_pc.push_back(m_pc);
                    q_ins.push_back(im[m_pc / 4]);
                    m_fetched = (m_fetched == 65535) ? 65535 : m_fetched + 1;
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("if_valid", {31'b0, if_valid}, {31'b0, q_pc.size() > 0});
        chk("Instr_addr", Instr_addr, m_pc);
        chk("if_halted", {31'b0, if_halted}, {31'b0, m_halt});
        if (q_pc.size() > 0) begin
            chk("if_pc", if_pc, q_pc[0]);
            chk("if_instr", if_instr, q_ins[0]);
        end
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", {16'b0, perf_fetched}, 32'(m_fetched));
        chk("perf_flushed", {16'b0, perf_flushed}, 32'(m_flushed));
`endif
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        @(posedge clk);
        model_edge(rv, rpc, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_instr"}, if_instr, 32'h0);
        chk({tag, "_addr"}, Instr_addr, 32'h0);
        chk({tag, "_halted"}, {31'b0, if_halted}, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_pfetch"}, {16'b0, perf_fetched}, 32'h0);
        chk({tag, "_pflush"}, {16'b0, perf_flushed}, 32'h0);
`endif
    endtask

    initial begin
        int          flushed_before;
        bit          rv;
        bit          rdy;
        logic [31:0] rpc;

        for (int i = 0; i < IMB / 4; i++) begin
            im[i] = (i < 8) ? 32'h1111_1111 * (i + 1) : $urandom;
        end
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Streaming from reset: one cycle latency then one word per cycle.
        step(0, 0, 1);
        chk("lat_pc0", if_pc, 32'h0);
        chk("lat_ins0", if_instr, 32'h1111_1111);
        step(0, 0, 1);
        chk("lat_pc4", if_pc, 32'h4);
        chk("lat_ins4", if_instr, 32'h2222_2222);
        step(0, 0, 1);
        chk("lat_pc8", if_pc, 32'h8);
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        // Backpressure: FIFO fills with exactly DEPTH words, pc holds.
        step(1, 32'h0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        chk("bp_addr", Instr_addr, 32'(4 * DEPTH));
        chk("bp_head", if_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 1);

        // Redirect with three entries queued.
        step(1, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        flushed_before = m_flushed;
        step(1, 32'h40, 1);
        chk("redir_valid", {31'b0, if_valid}, 32'h0);
        step(0, 0, 1);
        chk("redir_pc", if_pc, 32'h40);
`ifdef IF_PERF_CNT_EN
        chk("redir_flushed", 32'(perf_flushed) - 32'(flushed_before), 32'd3);
`endif

        // Running off the end of IM.
        step(1, 32'h70, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        chk("end_halted", {31'b0, if_halted}, 32'h1);
        chk("end_addr", Instr_addr, 32'h80);

        // Misaligned redirect halts; aligned redirect resumes.
        step(1, 32'h6, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("mis_halted", {31'b0, if_halted}, 32'h1);
        step(1, 32'h10, 1);
        chk("res_halted", {31'b0, if_halted}, 32'h0);
        step(0, 0, 1);
        chk("res_pc", if_pc, 32'h10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       rpc = 32'h7E;
                1:       rpc = 32'h200 + ($urandom_range(0, 3) * 4);
                2:       rpc = 32'h7C;
                default: rpc = $urandom_range(0, IMB / 4 - 1) * 4;
            endcase
            step(rv, rpc, rdy);
        end

        // Asynchronous reset mid-stream with a full FIFO.
        step(1, 32'h20, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        chk("pre_rst_full_addr", Instr_addr, 32'h20 + 32'(4 * DEPTH));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        chk("post_rst_pc", if_pc, 32'h0);
        step(0, 0, 1);
        chk("post_rst_pc4", if_pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
